// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch over imem req/ack, decode by
// instr[6:5], step EXEC/MEM/WB, update the 8-bit PC (incl. branches).
// Ports: clk, rst_n (sync, active low), run, imem_* (fetch handshake),
//   instr (IR), imm_data, alu_zero, alu_src_imm, dmem_* (data handshake),
//   reg_we, wb_sel_mem, pc, busy, fault (sticky timeout flag).
module cpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [7:0]  imm_data,
  input  logic        alu_zero,
  output logic        alu_src_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        wb_sel_mem,
  output logic [7:0]  pc,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD, C_ALUI, C_STORE, C_RTYPE, C_BRANCH
  } cls_t;

  // Last count value that may still wait; one more
  // idle cycle means the count reaches TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  cls_t        cls;
  logic [7:0]  pc_nx, cnt, cnt_nx;
  logic [31:0] instr_nx;
  logic        fault_nx;
  state_t      done_nx;

  assign imem_addr = pc;
  assign done_nx   = run ? S_FETCH : S_IDLE;

  // IR is stable from DECODE onwards, so the
  // class can be decoded straight from it.
  always_comb begin
    cls = C_ALUI;
    unique case (1'b1)
      instr[6:5] == 2'b00 &&  instr[4]: cls = C_LOAD;
      instr[6:5] == 2'b00 && !instr[4]: cls = C_ALUI;
      instr[6:5] == 2'b01:              cls = C_STORE;
      instr[6:5] == 2'b10:              cls = C_RTYPE;
      instr[6:5] == 2'b11:              cls = C_BRANCH;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    fault_nx = fault;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (run) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_nx = imem_rdata;
          state_nx = S_DECODE;
        end else if (cnt == TMO_LAST) begin
          state_nx = S_ERROR;
          fault_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_nx = S_MEM;
          C_BRANCH: begin
            pc_nx    = alu_zero ? pc + imm_data
                                : pc + 8'd1;
            state_nx = done_nx;
          end
          default: state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            pc_nx    = pc + 8'd1;
            state_nx = done_nx;
          end else begin
            state_nx = S_WB;
          end
        end else if (cnt == TMO_LAST) begin
          state_nx = S_ERROR;
          fault_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_WB: begin
        pc_nx    = pc + 8'd1;
        state_nx = done_nx;
      end
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_IDLE;
    endcase
    // Every state change restarts the wait count,
    // so FETCH/MEM always start counting from zero.
    if (state_nx != state) cnt_nx = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      cnt         <= 8'd0;
      fault       <= 1'b0;
      imem_req    <= 1'b0;
      alu_src_imm <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      reg_we      <= 1'b0;
      wb_sel_mem  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      cnt         <= cnt_nx;
      fault       <= fault_nx;
      // Outputs are registered copies of what the
      // next state drives.
      imem_req    <= state_nx == S_FETCH;
      alu_src_imm <= state_nx == S_EXEC
                     && cls != C_RTYPE;
      dmem_req    <= state_nx == S_MEM;
      dmem_we     <= state_nx == S_MEM
                     && cls == C_STORE;
      reg_we      <= state_nx == S_WB;
      wb_sel_mem  <= state_nx == S_WB
                     && cls == C_LOAD;
      busy        <= state_nx != S_IDLE
                     && state_nx != S_ERROR;
    end
  end

endmodule
